bt_link_supervisor: RTL and testbench



---
 rtl/bt_link_supervisor_if.sv | 20 ++
 rtl/bt_link_supervisor.sv | 201 ++++++++++++++++++++
 tb/tb_bt_link_supervisor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bt_link_supervisor_if.sv
// Avalon-MM slave port plus interrupt of the Bluetooth link supervisor.
interface bt_link_supervisor_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq
  );
endinterface

// File: rtl/bt_link_supervisor.sv
// Bluetooth module link supervisor: debounces the connect pin, sequences the
// module reset with timeout/retry, and reports link events over Avalon-MM.
//
// state     | meaning
// ----------+----------------------------------------------------------
// DISABLED  | supervisor off, module held in reset
// BT_RESET  | module reset pulse in progress
// WAIT_LINK | module released, waiting for debounced connect
// LINKED    | debounced connect seen, link reported up
// FAILED    | retries exhausted, module held in reset until restart
module bt_link_supervisor #(
  parameter int DEBOUNCE_CYCLES        = 1000,
  parameter int RESET_PULSE_CYCLES     = 50000,
  parameter int CONNECT_TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES            = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  bt_link_supervisor_if.slave         bus,
  input  logic                        connect_state_in,
  output logic                        bt_reset_n,
  output logic                        link_up
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (RESET_PULSE_CYCLES > CONNECT_TIMEOUT_CYCLES) ?
                           RESET_PULSE_CYCLES : CONNECT_TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD   = TMR_W'(CONNECT_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_DISABLED  = 3'd0,
    S_BT_RESET  = 3'd1,
    S_WAIT_LINK = 3'd2,
    S_LINKED    = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              conn_db_q, conn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [3:0]        retry_q, retry_d;
  logic [4:0]        control_q, control_d;
  logic [2:0]        event_q, event_d;
  logic [15:0]       link_cnt_q, link_cnt_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              bt_reset_n_q, bt_reset_n_d;
  logic [2:0]        ev_set;
  logic              link_inc;

  logic wr_ctrl, wr_event, wr_count, restart;
  logic en, auto_retry;
  logic unused_wdata;

  assign wr_ctrl    = bus.chipselect & bus.write & (bus.address == 2'd1);
  assign wr_event   = bus.chipselect & bus.write & (bus.address == 2'd2);
  assign wr_count   = bus.chipselect & bus.write & (bus.address == 2'd3);
  assign restart    = wr_ctrl & bus.writedata[5];
  assign en         = control_q[0];
  assign auto_retry = control_q[4];
  assign unused_wdata = ^bus.writedata[31:6];

  // Debouncer: conn_db follows the synchronized pin only after an unbroken run.
  always_comb begin
    sync_d    = {sync_q[0], connect_state_in};
    conn_db_d = conn_db_q;
    db_cnt_d  = '0;
    if (sync_q[1] != conn_db_q) begin
      if (db_cnt_q == DB_LAST) conn_db_d = sync_q[1];
      else                     db_cnt_d  = db_cnt_q + DB_W'(1);
    end
  end

  // FSM reacts to conn_db_d so a debounced edge and the state change land together.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    ev_set   = '0;
    link_inc = 1'b0;
    if (!en) begin
      state_d = S_DISABLED;
      tmr_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_DISABLED: begin
          state_d = S_BT_RESET;
          tmr_d   = PULSE_LOAD;
          retry_d = '0;
        end
        S_BT_RESET: begin
          if (tmr_q == '0) begin
            state_d = S_WAIT_LINK;
            tmr_d   = TMO_LOAD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        S_WAIT_LINK: begin
          if (conn_db_d) begin
            state_d   = S_LINKED;
            ev_set[0] = 1'b1;
            link_inc  = 1'b1;
            retry_d   = '0;
          end else if (tmr_q == '0) begin
            if (auto_retry && (retry_q < RETRY_MAX)) begin
              state_d = S_BT_RESET;
              tmr_d   = PULSE_LOAD;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d   = S_FAILED;
              ev_set[2] = 1'b1;
            end
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        S_LINKED: begin
          if (!conn_db_d) begin
            ev_set[1] = 1'b1;
            if (auto_retry) begin
              state_d = S_BT_RESET;
              tmr_d   = PULSE_LOAD;
            end else begin
              state_d = S_WAIT_LINK;
              tmr_d   = TMO_LOAD;
            end
          end
        end
        S_FAILED: begin
          if (restart) begin
            state_d = S_BT_RESET;
            tmr_d   = PULSE_LOAD;
            retry_d = '0;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end
  end

  always_comb begin
    bt_reset_n_d = (state_d == S_WAIT_LINK) || (state_d == S_LINKED);
    control_d    = wr_ctrl ? bus.writedata[4:0] : control_q;
    // A hardware set overrides a simultaneous write-one-to-clear.
    event_d      = (event_q & ~(wr_event ? bus.writedata[2:0] : 3'b000)) | ev_set;
    link_cnt_d   = link_cnt_q;
    if (wr_count)                            link_cnt_d = '0;
    else if (link_inc && (link_cnt_q != 16'hFFFF)) link_cnt_d = link_cnt_q + 16'd1;
    readdata_d   = readdata_q;
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        2'd0:    readdata_d = {24'd0, retry_q, state_q, conn_db_q};
        2'd1:    readdata_d = {27'd0, control_q};
        2'd2:    readdata_d = {29'd0, event_q};
        default: readdata_d = {16'd0, link_cnt_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_DISABLED;
      sync_q       <= '0;
      conn_db_q    <= 1'b0;
      db_cnt_q     <= '0;
      tmr_q        <= '0;
      retry_q      <= '0;
      control_q    <= '0;
      event_q      <= '0;
      link_cnt_q   <= '0;
      readdata_q   <= '0;
      bt_reset_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      conn_db_q    <= conn_db_d;
      db_cnt_q     <= db_cnt_d;
      tmr_q        <= tmr_d;
      retry_q      <= retry_d;
      control_q    <= control_d;
      event_q      <= event_d;
      link_cnt_q   <= link_cnt_d;
      readdata_q   <= readdata_d;
      bt_reset_n_q <= bt_reset_n_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(event_q & control_q[3:1]);
  assign bt_reset_n   = bt_reset_n_q;
  assign link_up      = conn_db_q && (state_q == S_LINKED);

endmodule

// File: tb/tb_bt_link_supervisor.sv
// Directed bench for bt_link_supervisor with small timing parameters.
module tb_bt_link_supervisor;

  logic clk = 1'b0;
  logic reset_n;
  logic connect_state_in;
  logic bt_reset_n;
  logic link_up;
  int   errors = 0;
  int   checks = 0;
  int   n;
  logic [31:0] rd;

  bt_link_supervisor_if bus ();

  bt_link_supervisor #(
    .DEBOUNCE_CYCLES        (4),
    .RESET_PULSE_CYCLES     (8),
    .CONNECT_TIMEOUT_CYCLES (32),
    .MAX_RETRIES            (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .connect_state_in (connect_state_in),
    .bt_reset_n       (bt_reset_n),
    .link_up          (link_up)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    data = bus.readdata;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bt_reset_n;
      1:       return link_up;
      default: return bus.irq;
    endcase
  endfunction

  // Cycles elapsed until the selected output reaches lvl, bounded by budget.
  task automatic wait_sig(input string tag, input int which, input logic lvl,
                          input int budget, output int cnt);
    cnt = 0;
    while (sig(which) !== lvl && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, 32'(sig(which) === lvl), 32'd1);
  endtask

  initial begin
    reset_n          = 1'b0;
    connect_state_in = 1'b0;
    bus.chipselect   = 1'b0;
    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.address      = '0;
    bus.writedata    = '0;
    cyc(3);
    chk("rst_bt_reset_n", 32'(bt_reset_n), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    bus_read(2'd0, rd);
    chk("status_after_reset", rd, 32'h0);

    // Enable: one cycle for CONTROL to reach the FSM, then the 8-cycle pulse.
    bus_write(2'd1, 32'h03);
    wait_sig("wait_release", 0, 1'b1, 40, n);
    chk("first_pulse_len", n, 9);

    // 3-cycle glitch must not pass the 4-cycle debouncer.
    cyc(2);
    connect_state_in = 1'b1;
    cyc(3);
    connect_state_in = 1'b0;
    cyc(6);
    bus_read(2'd0, rd);
    chk("glitch_status", rd, 32'h004);

    // Pin rise: 2 sync + 4 debounce cycles, FSM moves on the same edge.
    connect_state_in = 1'b1;
    wait_sig("wait_link", 1, 1'b1, 20, n);
    chk("link_latency", n, 6);
    bus_read(2'd0, rd);
    chk("linked_status", rd, 32'h007);
    bus_read(2'd2, rd);
    chk("event_connect", rd, 32'h1);
    chk("irq_connect", 32'(bus.irq), 32'd1);
    bus_read(2'd3, rd);
    chk("link_count_1", rd, 32'd1);
    bus_write(2'd2, 32'h1);
    chk("irq_after_w1c", 32'(bus.irq), 32'd0);
    bus_read(2'd2, rd);
    chk("event_cleared", rd, 32'h0);

    // Disconnect with auto_retry=0 goes back to WAIT_LINK, module stays released.
    connect_state_in = 1'b0;
    wait_sig("wait_unlink", 1, 1'b0, 20, n);
    chk("unlink_latency", n, 6);
    chk("disc_bt_reset_n", 32'(bt_reset_n), 32'd1);
    bus_read(2'd0, rd);
    chk("disc_status", rd, 32'h004);
    bus_read(2'd2, rd);
    chk("event_disconnect", rd, 32'h2);
    chk("disc_irq_masked", 32'(bus.irq), 32'd0);

    // Auto-retry twice, then FAILED with retry count 2.
    bus_write(2'd2, 32'h7);
    bus_write(2'd1, 32'h19);
    wait_sig("wait_retry1", 0, 1'b0, 60, n);
    wait_sig("wait_retry1_end", 0, 1'b1, 20, n);
    chk("retry1_pulse_len", n, 8);
    bus_read(2'd0, rd);
    chk("retry1_status", rd, 32'h014);
    wait_sig("wait_retry2", 0, 1'b0, 60, n);
    wait_sig("wait_retry2_end", 0, 1'b1, 20, n);
    chk("retry2_pulse_len", n, 8);
    bus_read(2'd0, rd);
    chk("retry2_status", rd, 32'h024);
    wait_sig("wait_fail_irq", 2, 1'b1, 60, n);
    bus_read(2'd0, rd);
    chk("failed_status", rd, 32'h028);
    bus_read(2'd2, rd);
    chk("event_fail", rd, 32'h4);
    chk("failed_bt_reset_n", 32'(bt_reset_n), 32'd0);

    // Restart strobe leaves FAILED; the strobe bit is not stored.
    bus_write(2'd1, 32'h39);
    bus_read(2'd0, rd);
    chk("restart_status", rd, 32'h002);
    bus_read(2'd1, rd);
    chk("control_readback", rd, 32'h19);
    chk("restart_bt_reset_n", 32'(bt_reset_n), 32'd0);

    // Clearing enable mid-pulse: DISABLED, EVENT and LINK_COUNT kept.
    bus_write(2'd1, 32'h00);
    cyc(1);
    bus_read(2'd0, rd);
    chk("disable_status", rd, 32'h000);
    chk("disable_bt_reset_n", 32'(bt_reset_n), 32'd0);
    bus_read(2'd2, rd);
    chk("disable_event_kept", rd, 32'h4);
    bus_read(2'd3, rd);
    chk("disable_count_kept", rd, 32'd1);

    // Asynchronous reset in the middle of a reset pulse.
    bus_write(2'd1, 32'h09);
    chk("pre_reset_irq", 32'(bus.irq), 32'd1);
    cyc(4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_bt_reset_n", 32'(bt_reset_n), 32'd0);
    chk("async_irq", 32'(bus.irq), 32'd0);
    cyc(2);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    chk("post_reset_bt_reset_n", 32'(bt_reset_n), 32'd0);
    bus_read(2'd1, rd);
    chk("post_reset_control", rd, 32'h0);
    bus_read(2'd2, rd);
    chk("post_reset_event", rd, 32'h0);
    bus_read(2'd3, rd);
    chk("post_reset_count", rd, 32'h0);

    // LINK_COUNT saturation from a preloaded 0xFFFF.
    force dut.link_cnt_q = 16'hFFFF;
    cyc(2);
    release dut.link_cnt_q;
    bus_read(2'd3, rd);
    chk("count_preload", rd, 32'hFFFF);
    connect_state_in = 1'b1;
    bus_write(2'd1, 32'h03);
    wait_sig("wait_link_sat", 1, 1'b1, 40, n);
    bus_read(2'd3, rd);
    chk("count_saturated", rd, 32'hFFFF);
    bus_read(2'd2, rd);
    chk("sat_event_connect", rd, 32'h1);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd);
    chk("count_write_clear", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
